// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants, field-select encodings and BCD helpers for the time counter
package clock_pkg;

  localparam int FIELD_W = 8;

  typedef enum logic [1:0] {
    SEL_SS   = 2'd0,
    SEL_MM   = 2'd1,
    SEL_HH   = 2'd2,
    SEL_NONE = 2'd3
  } adj_sel_e;

  // For well-formed BCD, a plain numeric compare preserves decimal ordering.
  function automatic logic is_valid_bcd(input logic [FIELD_W-1:0] value,
                                        input logic [FIELD_W-1:0] max);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
  endfunction

  function automatic logic [FIELD_W-1:0] to_bcd(input int value);
    logic [FIELD_W-1:0] r;
    r[7:4] = 4'(value / 10);
    r[3:0] = 4'(value % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD modulo counter with preset load and wrap flag
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [FIELD_W-1:0] MAX_BCD = 8'h59,
  parameter logic [FIELD_W-1:0] RST_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_val,
  output logic [FIELD_W-1:0] q,
  output logic               wrap
);

  assign wrap = inc && (q == MAX_BCD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      if (q == MAX_BCD) begin
        q <= '0;
      end else if (q[3:0] == 4'd9) begin
        q <= {q[7:4] + 4'd1, 4'd0};
      end else begin
        q <= {q[7:4], q[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - hh:mm:ss packed-BCD timekeeper with preset load and per-field adjust
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int                 HOUR_MAX = 23,
  parameter logic [FIELD_W-1:0] RST_HH   = 8'h00,
  parameter logic [FIELD_W-1:0] RST_MM   = 8'h00,
  parameter logic [FIELD_W-1:0] RST_SS   = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tick,
  input  logic        i_load,
  input  logic [23:0] i_load_time,
  input  logic        i_adj_en,
  input  logic [1:0]  i_adj_sel,
  input  logic        i_adj_inc,
  output logic [23:0] o_time,
  output logic        o_min_pulse,
  output logic        o_day_pulse,
  output logic        o_running
);

  localparam logic [FIELD_W-1:0] HH_MAX_BCD = to_bcd(HOUR_MAX);
  localparam logic [FIELD_W-1:0] MS_MAX_BCD = 8'h59;

  logic               adj_mode;
  logic               count_mode;
  logic               adj_ss, adj_mm, adj_hh;
  logic               ss_inc, mm_inc, hh_inc;
  logic               ss_wrap, mm_wrap, hh_wrap;
  logic [FIELD_W-1:0] ss_q, mm_q, hh_q;
  logic [FIELD_W-1:0] ld_ss, ld_mm, ld_hh;

  // Load outranks adjust, adjust outranks the tick.
  assign adj_mode   = !i_load && i_adj_en;
  assign count_mode = !i_load && !i_adj_en && i_tick;

  assign adj_ss = adj_mode && i_adj_inc && (i_adj_sel == SEL_SS);
  assign adj_mm = adj_mode && i_adj_inc && (i_adj_sel == SEL_MM);
  assign adj_hh = adj_mode && i_adj_inc && (i_adj_sel == SEL_HH);

  // Carries ripple only while counting; manual adjust never spills into the next field.
  assign ss_inc = count_mode || adj_ss;
  assign mm_inc = (count_mode && ss_wrap) || adj_mm;
  assign hh_inc = (count_mode && mm_wrap) || adj_hh;

  assign ld_ss = is_valid_bcd(i_load_time[7:0],   MS_MAX_BCD) ? i_load_time[7:0]   : '0;
  assign ld_mm = is_valid_bcd(i_load_time[15:8],  MS_MAX_BCD) ? i_load_time[15:8]  : '0;
  assign ld_hh = is_valid_bcd(i_load_time[23:16], HH_MAX_BCD) ? i_load_time[23:16] : '0;

  bcd_mod_counter #(.MAX_BCD(MS_MAX_BCD), .RST_VAL(RST_SS)) u_ss (
    .clk      (i_clk),
    .rst      (i_rst),
    .inc      (ss_inc),
    .load     (i_load),
    .load_val (ld_ss),
    .q        (ss_q),
    .wrap     (ss_wrap)
  );

  bcd_mod_counter #(.MAX_BCD(MS_MAX_BCD), .RST_VAL(RST_MM)) u_mm (
    .clk      (i_clk),
    .rst      (i_rst),
    .inc      (mm_inc),
    .load     (i_load),
    .load_val (ld_mm),
    .q        (mm_q),
    .wrap     (mm_wrap)
  );

  bcd_mod_counter #(.MAX_BCD(HH_MAX_BCD), .RST_VAL(RST_HH)) u_hh (
    .clk      (i_clk),
    .rst      (i_rst),
    .inc      (hh_inc),
    .load     (i_load),
    .load_val (ld_hh),
    .q        (hh_q),
    .wrap     (hh_wrap)
  );

  assign o_time = {hh_q, mm_q, ss_q};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_min_pulse <= 1'b0;
      o_day_pulse <= 1'b0;
      o_running   <= 1'b1;
    end else begin
      o_min_pulse <= count_mode && ss_wrap;
      o_day_pulse <= count_mode && hh_wrap;
      o_running   <= !i_adj_en;
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - directed and randomized checks of bcd_time_counter against a seconds-of-day model
module tb_bcd_time_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        ld = 1'b0;
  logic [23:0] ldt = '0;
  logic        adj_en = 1'b0;
  logic [1:0]  sel = '0;
  logic        adj_inc = 1'b0;

  logic [23:0] t0, t1;
  logic        min0, day0, run0, min1, day1, run1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Instance 0: 24 h clock, default reset. Instance 1: 12 h count, resets to 08:00:00.
  bcd_time_counter dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_load(ld), .i_load_time(ldt),
    .i_adj_en(adj_en), .i_adj_sel(sel), .i_adj_inc(adj_inc),
    .o_time(t0), .o_min_pulse(min0), .o_day_pulse(day0), .o_running(run0)
  );

  bcd_time_counter #(.HOUR_MAX(11), .RST_HH(8'h08)) dut_r (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_load(ld), .i_load_time(ldt),
    .i_adj_en(adj_en), .i_adj_sel(sel), .i_adj_inc(adj_inc),
    .o_time(t1), .o_min_pulse(min1), .o_day_pulse(day1), .o_running(run1)
  );

  function automatic int hmax(input int k);
    return (k == 0) ? 23 : 11;
  endfunction

  function automatic int rsec(input int k);
    return (k == 0) ? 0 : 8 * 3600;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int fld(input logic [7:0] v, input int max);
    int hi, lo, val;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9) return 0;
    val = hi * 10 + lo;
    return (val > max) ? 0 : val;
  endfunction

  function automatic int lsec(input logic [23:0] v, input int hm);
    return fld(v[23:16], hm) * 3600 + fld(v[15:8], 59) * 60 + fld(v[7:0], 59);
  endfunction

  function automatic int nxt(input int k, input int t);
    int hm, h, m, s;
    hm = hmax(k);
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    if (ld) return lsec(ldt, hm);
    if (adj_en) begin
      if (adj_inc) begin
        case (sel)
          2'd0: s = (s + 1) % 60;
          2'd1: m = (m + 1) % 60;
          2'd2: h = (h + 1) % (hm + 1);
          default: ;
        endcase
      end
      return h * 3600 + m * 60 + s;
    end
    if (tick) return (t + 1) % ((hm + 1) * 3600);
    return t;
  endfunction

  int ts[2];
  bit m_min[2], m_day[2];
  bit m_run;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        ts[k]    <= rsec(k);
        m_min[k] <= 1'b0;
        m_day[k] <= 1'b0;
      end
      m_run <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        ts[k]    <= nxt(k, ts[k]);
        m_min[k] <= (!ld && !adj_en && tick) && (nxt(k, ts[k]) % 60 == 0);
        m_day[k] <= (!ld && !adj_en && tick) && (nxt(k, ts[k]) == 0);
      end
      m_run <= !adj_en;
    end
  end

  function automatic logic [23:0] exp_time(input int k);
    int t;
    t = ts[k];
    return {bcd(t / 3600), bcd((t / 60) % 60), bcd(t % 60)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_time0", 32'(t0), 32'(exp_time(0)));
      chk("cyc_min0",  32'(min0), 32'(m_min[0]));
      chk("cyc_day0",  32'(day0), 32'(m_day[0]));
      chk("cyc_run0",  32'(run0), 32'(m_run));
      chk("cyc_time1", 32'(t1), 32'(exp_time(1)));
      chk("cyc_min1",  32'(min1), 32'(m_min[1]));
      chk("cyc_day1",  32'(day1), 32'(m_day[1]));
      chk("cyc_run1",  32'(run1), 32'(m_run));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_load(input logic [23:0] v);
    ld = 1'b1;
    ldt = v;
    step();
    ld = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) step();
    chk("rst_time0", 32'(t0), 32'h000000);
    chk("rst_time1", 32'(t1), 32'h080000);
    chk("rst_run", 32'(run0), 32'd1);
    chk("rst_pulses", 32'({min0, day0}), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 3; i++) begin
      do_tick();
      repeat (99) step();
    end
    chk("ticks3_time", 32'(t0), 32'h000003);
    chk("ticks3_model", 32'(exp_time(0)), 32'h000003);
    chk("ticks3_run", 32'(run0), 32'd1);

    do_load(24'h235958);
    chk("load_235958", 32'(t0), 32'h235958);
    do_tick();
    chk("tick_235959", 32'(t0), 32'h235959);
    chk("tick_235959_min", 32'(min0), 32'd0);
    do_tick();
    chk("wrap_time", 32'(t0), 32'h000000);
    chk("wrap_min", 32'(min0), 32'd1);
    chk("wrap_day", 32'(day0), 32'd1);
    chk("wrap_model_day", 32'(m_day[0]), 32'd1);
    step();
    chk("wrap_min_end", 32'(min0), 32'd0);
    chk("wrap_day_end", 32'(day0), 32'd0);

    do_load(24'h127A30);
    chk("load_bad_mm", 32'(t0), 32'h120030);
    do_load(24'h240000);
    chk("load_bad_hh", 32'(t0), 32'h000000);
    chk("load_bad_hh12", 32'(t1), 32'h000000);

    do_load(24'h105959);
    adj_en = 1'b1;
    sel = 2'd0;
    adj_inc = 1'b1;
    step();
    adj_inc = 1'b0;
    chk("adj_ss", 32'(t0), 32'h105900);
    chk("adj_run", 32'(run0), 32'd0);
    chk("adj_pulses", 32'({min0, day0}), 32'd0);
    tick = 1'b1;
    repeat (5) step();
    tick = 1'b0;
    chk("adj_ticks", 32'(t0), 32'h105900);
    chk("adj_ticks_run", 32'(run0), 32'd0);
    adj_en = 1'b0;
    step();
    chk("adj_exit_run", 32'(run0), 32'd1);

    tick = 1'b1;
    do_load(24'h010203);
    tick = 1'b0;
    chk("load_tick", 32'(t0), 32'h010203);

    do_load(24'h075920);
    repeat (10) do_tick();
    chk("pre_rst", 32'(t1), 32'h075930);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst1", 32'(t1), 32'h080000);
    chk("async_rst0", 32'(t0), 32'h000000);
    chk("async_rst_pulses", 32'({min0, day0, min1, day1}), 32'd0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 1)
        ldt = 24'($urandom);
      else
        ldt = {bcd($urandom_range(0, 23)), 8'h59, 4'h5, 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 29) == 0) adj_en = ~adj_en;
      sel = 2'($urandom_range(0, 3));
      adj_inc = ($urandom_range(0, 1) == 1);
      tick = ($urandom_range(0, 1) == 1);
    end
    step();
    rst = 1'b0;
    ld = 1'b0;
    tick = 1'b0;
    adj_en = 1'b0;
    adj_inc = 1'b0;
    step();
    step();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Timekeeping stage directly downstream of the even clock divider. Consumes the divider's one-cycle 1 Hz enable pulse and keeps hh:mm:ss as packed BCD.
- Feeds the seven-segment scan and alarm logic.
- Supports a synchronous preset load and per-field manual adjust for the front-panel keys.
- Everything runs in the single system clock domain. No derived clocks.

Parameters:
- HOUR_MAX, 23: last hour value before wrap. 23 gives a 24 h clock; 11 gives a 00–11 style 12 h count. Legal range 1..23.
- RST_HH, 8'h00: BCD hour value loaded on reset.
- RST_MM, 8'h00: BCD minute value loaded on reset.
- RST_SS, 8'h00: BCD second value loaded on reset.

Ports:
- i_clk  input  1  system clock, 100 MHz
- i_rst  input  1  asynchronous, active-high reset
- i_tick  input  1  one-cycle count enable, from the divider's o_clk_en
- i_load  input  1  synchronous preset strobe
- i_load_time  input  24  preset {hh,mm,ss}, packed BCD, two digits per field
- i_adj_en  input  1  adjust mode; pauses counting while high
- i_adj_sel  input  2  field select: 0 = ss, 1 = mm, 2 = hh, 3 = none
- i_adj_inc  input  1  one-cycle increment strobe for the selected field
- o_time  output  24  current {hh,mm,ss}, packed BCD, registered
- o_min_pulse  output  1  one-cycle pulse when ss wraps 59→00 on a tick
- o_day_pulse  output  1  one-cycle pulse when the whole time wraps HOUR_MAX:59:59→00:00:00 on a tick
- o_running  output  1  high when ticks are being counted (= ~i_adj_en, registered)

Behaviour:
- Reset (i_rst high, async):
  - o_time = {RST_HH,RST_MM,RST_SS}.
  - o_min_pulse = 0, o_day_pulse = 0, o_running = 1.
  - Counting resumes on the first tick after reset is released.
- Priority per clock edge: reset > load > adjust > tick. Only one of load, adjust or tick acts in a given cycle.
- Load (i_load = 1):
  - o_time takes i_load_time on the next edge.
  - Each field is validated separately. A field with a digit > 9, ss or mm > 0x59, or hh > HOUR_MAX is replaced by 0x00. Valid fields load unchanged.
  - A tick in the same cycle is dropped. No pulses are emitted.
- Adjust (i_adj_en = 1):
  - Ticks are ignored. o_running = 0 on the next edge.
  - i_adj_inc = 1 increments the field chosen by i_adj_sel by 1, wrapping 59→00 (hh: HOUR_MAX→00).
  - No carry into the next field. No pulses are emitted.
  - i_adj_sel = 3 makes i_adj_inc a no-op.
- Tick (i_tick = 1, not loading, not adjusting):
  - ss increments.
  - ss 59→00 carries into mm and asserts o_min_pulse.
  - mm 59→00 carries into hh.
  - hh HOUR_MAX→00 when carried into, which asserts o_day_pulse.
  - Full carry chain completes in the same cycle. Latency is one edge: the new o_time and the pulses appear together, registered, one cycle after the tick sample.
- BCD arithmetic: low digit 9→0 with carry to high digit. The high digit never exceeds 5 for ss/mm, or the tens digit of HOUR_MAX for hh. Binary intermediates are never exposed.
- Pulses are exactly one cycle wide. Back-to-back ticks (testbench only) each advance the time once.
- i_tick high for several consecutive cycles counts once per cycle. Edge detection is the producer's job.
- Reset asserted mid-operation (mid-adjust, mid-pulse) returns every output to its reset value immediately.
- All outputs are flops. No combinational path from input to output.

Decomposition:
- Shared package (clock_pkg) holds:
  - BCD field width constant (8).
  - Field-select encodings SEL_SS, SEL_MM, SEL_HH, SEL_NONE.
  - Function is_valid_bcd(value, max) used by load validation.
- One sub-module, bcd_mod_counter, instantiated three times.
  - Parameter MAX_BCD.
  - Ports: clk, rst, inc, load, load_val, q[7:0], wrap.
  - `wrap` is combinational: high when inc and q == MAX_BCD.
  - The top level chains each instance's wrap into the next field's inc, gated by mode, and registers the pulses.

Test Plan:
- Reset with defaults, then release, then 3 ticks spaced 100 cycles apart → o_time = 0x000003, o_running = 1, no pulses.
- Load 0x235958, then 2 ticks → o_time goes to 0x235959, then 0x000000. o_min_pulse and o_day_pulse are both high for exactly one cycle on the second update.
- Load 0x12_7A_30 (invalid mm) → o_time = 0x120030. Load 0x24_00_00 with HOUR_MAX = 23 → o_time = 0x000000.
- With i_adj_en = 1 and o_time = 0x105959:
  - i_adj_sel = 0, one i_adj_inc → 0x105900. mm and hh unchanged, no pulses.
  - Ticks during adjust → o_time unchanged, o_running = 0.
- i_load and i_tick in the same cycle with load value 0x010203 → o_time = 0x010203, not 0x010204.
- i_rst asserted mid-count at o_time = 0x075930 with RST_HH = 0x08 → o_time = 0x080000 asynchronously, before the next clock edge. Pulses are 0.
